// File: rtl/motion_sequencer.sv
// Queues drive commands and runs them one at a time on the left/right wheel step controllers.
// Optional build macro SEQ_STATS_EN adds the moves_done completed-move counter output.
module motion_sequencer #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter logic [15:0] START_WAIT = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_degs,
  output logic        cmd_ready,
  input  logic        flush,
  output logic        en_l,
  output logic        en_r,
  output logic [15:0] ndegs_l,
  output logic [15:0] ndegs_r,
  output logic        dir_l,
  output logic        dir_r,
  input  logic        busy_l,
  input  logic        busy_r,
  output logic        done,
  output logic        idle,
  output logic        fault
`ifdef SEQ_STATS_EN
  ,output logic [15:0] moves_done
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_RUN       = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // Returns {dir_l, dir_r} for an opcode; 1 means the wheel turns forward.
  function automatic logic [1:0] dir_map(input logic [1:0] op);
    case (op)
      2'd0:    dir_map = 2'b11;
      2'd1:    dir_map = 2'b00;
      2'd2:    dir_map = 2'b01;
      2'd3:    dir_map = 2'b10;
      default: dir_map = 2'b00;
    endcase
  endfunction

  state_t        state_r, state_next_s;
  logic [17:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_next_s;
  logic [17:0]   head_s;
  logic          push_s, pop_s, empty_s, both_seen_s;
  logic          timeout_s, done_set_s;
  logic [15:0]   wait_cnt_r, gap_cnt_r;
  logic          seen_l_r, seen_r_r;

  assign push_s      = cmd_valid & cmd_ready & ~flush;
  assign empty_s     = (count_r == '0);
  assign head_s      = mem_r[rd_ptr_r];
  assign both_seen_s = (seen_l_r | busy_l) & (seen_r_r | busy_r);

  // Next FIFO occupancy; flush wins over any simultaneous push.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1'b1);
        2'b01:   count_next_s = count_r - CW'(1'b1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Sequencer next-state and per-cycle events.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    timeout_s    = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s && !flush) begin
          pop_s        = 1'b1;
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD:  state_next_s = S_START;
      S_START: state_next_s = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (both_seen_s) begin
          state_next_s = S_RUN;
        end else if (wait_cnt_r == START_WAIT) begin
          timeout_s    = 1'b1;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_WAIT_BUSY;
        end
      end
      S_RUN: begin
        if (!busy_l && !busy_r) begin
          done_set_s   = 1'b1;
          state_next_s = S_GAP;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_CYCLES) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_GAP;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_next_s;
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {cmd_op, cmd_degs};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      count_r <= count_next_s;
      if (flush) begin
        rd_ptr_r <= wr_ptr_r;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
    end
  end

  // Start-timeout counter, per-wheel busy latches and inter-move gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 16'd0;
      gap_cnt_r  <= 16'd0;
      seen_l_r   <= 1'b0;
      seen_r_r   <= 1'b0;
    end else begin
      case (state_r)
        S_START: begin
          wait_cnt_r <= 16'd0;
          seen_l_r   <= 1'b0;
          seen_r_r   <= 1'b0;
        end
        S_WAIT_BUSY: begin
          wait_cnt_r <= wait_cnt_r + 16'd1;
          seen_l_r   <= seen_l_r | busy_l;
          seen_r_r   <= seen_r_r | busy_r;
        end
        S_RUN:   gap_cnt_r <= 16'd0;
        S_GAP:   gap_cnt_r <= gap_cnt_r + 16'd1;
        default: begin
        end
      endcase
    end
  end

  // Registered outputs, computed from next-state so en_* is high exactly while in START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_l      <= 1'b0;
      en_r      <= 1'b0;
      ndegs_l   <= 16'd0;
      ndegs_r   <= 16'd0;
      dir_l     <= 1'b0;
      dir_r     <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      cmd_ready <= 1'b1;
      idle      <= 1'b1;
    end else begin
      en_l      <= (state_next_s == S_START);
      en_r      <= (state_next_s == S_START);
      done      <= done_set_s;
      fault     <= fault | timeout_s;
      cmd_ready <= (count_next_s != FULL_CNT);
      idle      <= (state_next_s == S_IDLE) && (count_next_s == '0);
      if (pop_s) begin
        ndegs_l        <= head_s[15:0];
        ndegs_r        <= head_s[15:0];
        {dir_l, dir_r} <= dir_map(head_s[17:16]);
      end
    end
  end

`ifdef SEQ_STATS_EN
  // Completed-move counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             moves_done <= 16'd0;
    else if (done_set_s) moves_done <= moves_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed self-checking bench for motion_sequencer with a simple step-controller busy model.
module tb_motion_sequencer;
  localparam int          DEPTH = 4;
  localparam logic [15:0] GAP   = 16'd5;
  localparam logic [15:0] SW    = 16'd20;
  localparam logic [1:0]  FWD = 2'd0, REV = 2'd1, TURN_L = 2'd2, TURN_R = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_degs = 16'd0;
  logic        flush = 1'b0;
  logic        cmd_ready, en_l, en_r, dir_l, dir_r, done, idle, fault;
  logic [15:0] ndegs_l, ndegs_r;
  logic        busy_l, busy_r;
`ifdef SEQ_STATS_EN
  logic [15:0] moves_done;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motion_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .START_WAIT(SW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_degs(cmd_degs),
    .cmd_ready(cmd_ready), .flush(flush), .en_l(en_l), .en_r(en_r),
    .ndegs_l(ndegs_l), .ndegs_r(ndegs_r), .dir_l(dir_l), .dir_r(dir_r),
    .busy_l(busy_l), .busy_r(busy_r), .done(done), .idle(idle), .fault(fault)
`ifdef SEQ_STATS_EN
    ,.moves_done(moves_done)
`endif
  );

  // Step-controller model: busy rises 3 clocks after the en pulse and stays high len clocks.
  logic        stall_r = 1'b0;
  logic [15:0] len_l = 16'd100, len_r = 16'd100;
  logic [15:0] tmr_l, tmr_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_l <= 16'd0; busy_l <= 1'b0;
    end else if (en_l) begin
      tmr_l <= 16'd1;
    end else if (tmr_l != 16'd0) begin
      tmr_l <= tmr_l + 16'd1;
      if (tmr_l == 16'd2) busy_l <= 1'b1;
      if (tmr_l == 16'd2 + len_l) begin busy_l <= 1'b0; tmr_l <= 16'd0; end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_r <= 16'd0; busy_r <= 1'b0;
    end else if (en_r && !stall_r) begin
      tmr_r <= 16'd1;
    end else if (tmr_r != 16'd0) begin
      tmr_r <= tmr_r + 16'd1;
      if (tmr_r == 16'd2) busy_r <= 1'b1;
      if (tmr_r == 16'd2 + len_r) begin busy_r <= 1'b0; tmr_r <= 16'd0; end
    end
  end

  // Pulse monitor sampled just after each rising edge.
  int cyc = 0, en_cnt = 0, done_cnt = 0, last_en_cyc = 0, last_done_cyc = 0;
  int en_long = 0, done_long = 0, en_mis = 0, ndegs_sum = 0;
  logic [15:0] last_ndegs = 16'd0;
  logic prev_en = 1'b0, prev_done = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (en_l !== en_r) en_mis++;
    if (en_l === 1'b1) begin
      en_cnt++; last_en_cyc = cyc; ndegs_sum += int'(ndegs_l); last_ndegs = ndegs_l;
      if (prev_en) en_long++;
    end
    if (done === 1'b1) begin
      done_cnt++; last_done_cyc = cyc;
      if (prev_done) done_long++;
    end
    prev_en = en_l;
    prev_done = done;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_degs = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input string nm, output int k);
    k = 0;
    while (en_l !== 1'b1 && k < 300) begin tick(); k++; end
    checks++; if (en_l !== 1'b1) begin failures++; $display("FAIL %s: en_l=%b after %0d clks, required 1", nm, en_l, k); end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (idle !== 1'b1 && k < budget) begin tick(); k++; end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL %s: idle=%b after %0d clks, required 1", nm, idle, k); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (en_l !== 1'b0 || en_r !== 1'b0) begin failures++; $display("FAIL rst_en: got %b%b want 00", en_l, en_r); end
    checks++; if (ndegs_l !== 16'd0 || ndegs_r !== 16'd0) begin failures++; $display("FAIL rst_ndegs: got %0d/%0d want 0/0", ndegs_l, ndegs_r); end
    checks++; if ({dir_l, dir_r} !== 2'b00) begin failures++; $display("FAIL rst_dir: got %b%b want 00", dir_l, dir_r); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", fault); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b want 1", idle); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fwd();
    int k, e0, d0, el0, dl0;
    len_l = 16'd100; len_r = 16'd100;
    e0 = en_cnt; d0 = done_cnt; el0 = en_long; dl0 = done_long;
    push(FWD, 16'd720);
    wait_en("fwd_en", k);
    checks++; if (k != 2) begin failures++; $display("FAIL fwd_latency: got %0d want 2", k); end
    checks++; if (en_r !== 1'b1) begin failures++; $display("FAIL fwd_en_r: got %b want 1", en_r); end
    checks++; if (ndegs_l !== 16'd720 || ndegs_r !== 16'd720) begin failures++; $display("FAIL fwd_ndegs: got %0d/%0d want 720/720", ndegs_l, ndegs_r); end
    checks++; if ({dir_l, dir_r} !== 2'b11) begin failures++; $display("FAIL fwd_dir: got %b%b want 11", dir_l, dir_r); end
    wait_idle("fwd_idle", 400);
    checks++; if (en_cnt - e0 != 1) begin failures++; $display("FAIL fwd_en_count: got %0d want 1", en_cnt - e0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL fwd_done_count: got %0d want 1", done_cnt - d0); end
    // en edge + 3 to busy + 100 busy clocks + 1 to observe both low
    checks++; if (last_done_cyc - last_en_cyc != 104) begin failures++; $display("FAIL fwd_move_time: got %0d want 104", last_done_cyc - last_en_cyc); end
    checks++; if (en_long != el0 || done_long != dl0 || en_mis != 0) begin failures++; $display("FAIL fwd_pulse_width: en_long=%0d done_long=%0d en_mis=%0d want %0d %0d 0", en_long, done_long, en_mis, el0, dl0); end
    checks++; if (ndegs_l !== 16'd720 || fault !== 1'b0) begin failures++; $display("FAIL fwd_hold: ndegs_l=%0d fault=%b want 720 0", ndegs_l, fault); end
  endtask

  task automatic test_back_to_back();
    int k, e0, d0;
    len_l = 16'd20; len_r = 16'd20;
    e0 = en_cnt; d0 = done_cnt;
    push(TURN_L, 16'd90);
    push(TURN_R, 16'd90);
    wait_en("tl_en", k);
    checks++; if ({dir_l, dir_r} !== 2'b01 || ndegs_l !== 16'd90) begin failures++; $display("FAIL tl_out: dir=%b%b ndegs=%0d want 01 90", dir_l, dir_r, ndegs_l); end
    tick();
    wait_en("tr_en", k);
    checks++; if ({dir_l, dir_r} !== 2'b10 || ndegs_r !== 16'd90) begin failures++; $display("FAIL tr_out: dir=%b%b ndegs=%0d want 10 90", dir_l, dir_r, ndegs_r); end
    checks++; if (last_en_cyc - last_done_cyc != int'(GAP) + 3) begin failures++; $display("FAIL b2b_gap: got %0d want %0d", last_en_cyc - last_done_cyc, int'(GAP) + 3); end
    wait_idle("b2b_idle", 300);
    checks++; if (en_cnt - e0 != 2 || done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_counts: en=%0d done=%0d want 2 2", en_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_fifo_full();
    int k, e0, d0, s0;
    len_l = 16'd60; len_r = 16'd60;
    e0 = en_cnt; d0 = done_cnt; s0 = ndegs_sum;
    push(FWD, 16'd50);
    wait_en("full_first", k);
    push(FWD, 16'd100);
    push(FWD, 16'd200);
    push(FWD, 16'd300);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_ready3: got %b want 1", cmd_ready); end
    push(FWD, 16'd400);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready4: got %b want 0", cmd_ready); end
    push(FWD, 16'd500);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready5: got %b want 0", cmd_ready); end
    wait_idle("full_idle", 1500);
    checks++; if (en_cnt - e0 != 5 || done_cnt - d0 != 5) begin failures++; $display("FAIL full_counts: en=%0d done=%0d want 5 5", en_cnt - e0, done_cnt - d0); end
    checks++; if (ndegs_sum - s0 != 1050 || last_ndegs !== 16'd400) begin failures++; $display("FAIL full_order: sum=%0d last=%0d want 1050 400", ndegs_sum - s0, last_ndegs); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_ready_end: got %b want 1", cmd_ready); end
  endtask

  task automatic test_start_timeout();
    int k, d0;
    len_l = 16'd30; len_r = 16'd30; stall_r = 1'b1;
    d0 = done_cnt;
    push(FWD, 16'd10);
    wait_en("flt_en", k);
    k = 0;
    while (fault !== 1'b1 && k < 200) begin tick(); k++; end
    checks++; if (fault !== 1'b1 || k < int'(SW) || k > int'(SW) + 2) begin failures++; $display("FAIL flt_time: fault=%b after %0d clks, want 1 after %0d..%0d", fault, k, int'(SW), int'(SW) + 2); end
    checks++; if (done_cnt - d0 != 0 || idle !== 1'b1) begin failures++; $display("FAIL flt_nodone: done=%0d idle=%b want 0 1", done_cnt - d0, idle); end
    repeat (40) tick();
    stall_r = 1'b0;
    push(REV, 16'd33);
    wait_en("flt_next_en", k);
    checks++; if ({dir_l, dir_r} !== 2'b00 || ndegs_r !== 16'd33) begin failures++; $display("FAIL flt_next_out: dir=%b%b ndegs=%0d want 00 33", dir_l, dir_r, ndegs_r); end
    wait_idle("flt_next_idle", 300);
    checks++; if (done_cnt - d0 != 1 || fault !== 1'b1) begin failures++; $display("FAIL flt_sticky: done=%0d fault=%b want 1 1", done_cnt - d0, fault); end
  endtask

  task automatic test_flush();
    int e0, d0;
    len_l = 16'd50; len_r = 16'd50;
    e0 = en_cnt; d0 = done_cnt;
    push(FWD, 16'd11);
    push(FWD, 16'd22);
    push(FWD, 16'd33);
    push(FWD, 16'd44);
    repeat (20) tick();
    flush = 1'b1; cmd_valid = 1'b1; cmd_op = FWD; cmd_degs = 16'd777;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    checks++; if (idle !== 1'b0 || done_cnt - d0 != 0) begin failures++; $display("FAIL flush_running: idle=%b done=%0d want 0 0", idle, done_cnt - d0); end
    wait_idle("flush_idle", 300);
    repeat (20) tick();
    checks++; if (en_cnt - e0 != 1 || done_cnt - d0 != 1) begin failures++; $display("FAIL flush_counts: en=%0d done=%0d want 1 1", en_cnt - e0, done_cnt - d0); end
    checks++; if (idle !== 1'b1 || last_ndegs !== 16'd11) begin failures++; $display("FAIL flush_end: idle=%b last=%0d want 1 11", idle, last_ndegs); end
  endtask

  task automatic test_reset_mid_run();
    int k;
    len_l = 16'd100; len_r = 16'd100;
    push(FWD, 16'd1000);
    wait_en("rr_en", k);
    repeat (20) tick();
    checks++; if (ndegs_l !== 16'd1000 || idle !== 1'b0 || fault !== 1'b1) begin failures++; $display("FAIL rr_pre: ndegs=%0d idle=%b fault=%b want 1000 0 1", ndegs_l, idle, fault); end
    rst = 1'b1;
    #1;
    checks++; if (ndegs_l !== 16'd0 || ndegs_r !== 16'd0 || {dir_l, dir_r} !== 2'b00) begin failures++; $display("FAIL rr_outs: ndegs=%0d/%0d dir=%b%b want 0/0 00", ndegs_l, ndegs_r, dir_l, dir_r); end
    checks++; if (en_l !== 1'b0 || en_r !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL rr_ctl: en=%b%b done=%b fault=%b want 00 0 0", en_l, en_r, done, fault); end
    checks++; if (cmd_ready !== 1'b1 || idle !== 1'b1) begin failures++; $display("FAIL rr_status: ready=%b idle=%b want 1 1", cmd_ready, idle); end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (idle !== 1'b1 || en_l !== 1'b0) begin failures++; $display("FAIL rr_after: idle=%b en=%b want 1 0", idle, en_l); end
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_back_to_back();
    test_fifo_full();
    test_start_timeout();
    test_flush();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
